// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle for the round-robin write-port arbiter.
// master = arbiter, slave = producers plus FIFO write port.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4
);
   logic [N_REQ-1:0]            req;
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            grant;
   logic [N_REQ-1:0]            ack;
   logic                        full;
   logic                        w_inc;
   logic [DATA_WIDTH-1:0]       wr_data;
   logic                        busy;

   modport master (
      input  req, req_data, full,
      output grant, ack, w_inc, wr_data, busy
   );

   modport slave (
      output req, req_data, full,
      input  grant, ack, w_inc, wr_data, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port; grant registered, first write in the cycle after req is sampled.
// full stalls the burst in place (w_inc/ack low, nothing dropped); bursts hand off with no idle cycle.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4,
   parameter int BURST_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst,
   fifo_wr_arbiter_if.master bus
);
   localparam int LW = $clog2(N_REQ);
   localparam int CW = $clog2(BURST_MAX) + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state;
   logic [N_REQ-1:0]  grant_reg;
   logic [LW-1:0]     last;
   logic [CW-1:0]     cnt;
   logic              busy_reg;

   logic                  owner_req;
   logic                  wr;
   logic                  end_full;
   logic                  end_withdraw;
   logic                  burst_end;
   logic [DATA_WIDTH-1:0] data_sel;
   logic [N_REQ-1:0]      pick_oh;
   logic [LW-1:0]         pick_idx;
   logic                  pick_found;
   int                    idx;
   logic [LW-1:0]         ix;

   // The owner index is always `last` while in BURST, so the one-hot grant drives the mux directly.
   always_comb begin
      data_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_reg[i]) begin
            data_sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      owner_req    = |(bus.req & grant_reg);
      wr           = (state == BURST) && owner_req && !bus.full;
      end_full     = wr && (cnt == CW'(BURST_MAX - 1));
      end_withdraw = (state == BURST) && !owner_req;
      burst_end    = end_full || end_withdraw;
   end

   // Search starts one past the previous owner and ends on it. On a withdraw the
   // owner's req is already low, so the raw req vector needs no extra mask.
   always_comb begin
      pick_oh    = '0;
      pick_idx   = '0;
      pick_found = 1'b0;
      idx        = 0;
      ix         = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         ix  = idx[LW-1:0];
         if (!pick_found && bus.req[ix]) begin
            pick_found  = 1'b1;
            pick_idx    = ix;
            pick_oh[ix] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_reg <= '0;
         last      <= LW'(N_REQ - 1);
         cnt       <= '0;
         busy_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state     <= BURST;
                  grant_reg <= pick_oh;
                  last      <= pick_idx;
                  cnt       <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            BURST: begin
               if (burst_end) begin
                  if (pick_found) begin
                     grant_reg <= pick_oh;
                     last      <= pick_idx;
                     cnt       <= '0;
                  end else begin
                     state     <= IDLE;
                     grant_reg <= '0;
                     cnt       <= '0;
                     busy_reg  <= 1'b0;
                  end
               end else if (wr) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state     <= IDLE;
               grant_reg <= '0;
               cnt       <= '0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant   = grant_reg;
   assign bus.busy    = busy_reg;
   assign bus.w_inc   = wr;
   assign bus.ack     = wr ? grant_reg : '0;
   assign bus.wr_data = data_sel;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter (N_REQ=4, BURST_MAX=4, 8-bit words).
module tb_fifo_wr_arbiter;
   localparam int DW    = 8;
   localparam int N     = 4;
   localparam int BM    = 4;
   localparam int DEPTH = 64;

   typedef struct packed {
      logic [N-1:0]  oh;
      logic [DW-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic full_force = 1'b0;
   logic fifo_full  = 1'b0;
   logic fifo_en    = 1'b0;
   logic rd_en      = 1'b0;

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(N)) bus ();
   fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .BURST_MAX(BM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   assign bus.full = full_force | fifo_full;

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int wr_cnt = 0;
   int wr_cyc [256];
   int rd_total = 0;
   int flush_gen = 0;

   exp_t          sb [$];
   logic [DW-1:0] rd_exp [$];
   logic [DW-1:0] fq [$];
   logic [DW-1:0] mem [N][128];
   int            head [N];
   int            tail [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic load(input int i, input logic [DW-1:0] d);
      mem[i][tail[i]] = d;
      tail[i] = tail[i] + 1;
   endtask

   task automatic expect_wr(input int i, input logic [DW-1:0] d);
      exp_t e;
      e.oh = N'(1 << i);
      e.d  = d;
      sb.push_back(e);
   endtask

   function automatic bit prod_empty();
      bit e = 1'b1;
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) e = 1'b0;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg_after(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_done(input string name, input int bound);
      bit ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (prod_empty() && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_done"}, 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      tick();
   endtask

   task automatic check_run(input string name, input int n0, input int c0,
                            input int exp_n, input int exp_span);
      chk({name, "_count"}, 32'(wr_cnt - n0), 32'(exp_n));
      if (wr_cnt > n0) begin
         chk({name, "_first"}, 32'(wr_cyc[n0]), 32'(c0 + 1));
         chk({name, "_span"}, 32'(wr_cyc[wr_cnt-1] - wr_cyc[n0] + 1), 32'(exp_span));
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Producers: each holds a word queue, presents the head, pops it the edge after its ack.
   initial begin
      logic [N-1:0] a;
      int seen;
      seen = 0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      bus.req      = '0;
      bus.req_data = '0;
      forever begin
         @(negedge clk);
         a = bus.ack;
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) if (a[i]) head[i] = head[i] + 1;
         if (seen != flush_gen) begin
            seen = flush_gen;
            for (int i = 0; i < N; i++) head[i] = tail[i];
         end
         for (int i = 0; i < N; i++) begin
            bus.req[i] = (head[i] < tail[i]);
            bus.req_data[i*DW +: DW] = (head[i] < tail[i]) ? mem[i][head[i]] : '0;
         end
      end
   end

   // Monitor: invariants every cycle, scoreboard pop on every write.
   initial forever begin
      exp_t e;
      logic [5:0] inv;
      @(negedge clk);
      if (!rst) begin
         inv = {bus.w_inc == (|bus.ack),
                (bus.ack & ~bus.grant) == '0,
                bus.busy == (|bus.grant),
                $onehot0(bus.grant),
                $onehot0(bus.ack),
                !(bus.full && bus.w_inc)};
         chk("invariants", 32'(inv), 32'h3f);
         if (bus.w_inc) begin
            if (wr_cnt < 256) wr_cyc[wr_cnt] = cyc;
            wr_cnt++;
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_write: got data %0h ack %0h want no write (cycle %0d)",
                        bus.wr_data, bus.ack, cyc);
            end else begin
               e = sb.pop_front();
               chk("wr_data", 32'(bus.wr_data), 32'(e.d));
               chk("ack", 32'(bus.ack), 32'(e.oh));
            end
         end
      end
   end

   // FIFO model on the write port: fills to DEPTH, read side enabled by the stimulus.
   initial forever begin
      logic          ws;
      logic [DW-1:0] wd;
      logic [DW-1:0] rd;
      @(negedge clk);
      ws = bus.w_inc & fifo_en;
      wd = bus.wr_data;
      @(posedge clk);
      #1;
      if (ws) fq.push_back(wd);
      if (rd_en && fq.size() > 0) begin
         rd = fq.pop_front();
         rd_total++;
         if (rd_exp.size() == 0) begin
            n_chk++;
            $display("FAIL fifo_rd_extra: got %0h want nothing", rd);
         end else begin
            chk("fifo_rd", 32'(rd), 32'(rd_exp.pop_front()));
         end
      end
      fifo_full = (fq.size() >= DEPTH);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want $finish");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1);
   end

   initial begin
      int c0;
      int n0;
      int snap;
      bit ok;

      // Reset state
      #3;
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_winc", 32'(bus.w_inc), 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;

      // All four continuous: 0001,0010,0100,1000, 4 words each, 16 back-to-back
      tick();
      c0 = cyc;
      n0 = wr_cnt;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 4; j++) begin
            load(i, DW'((i << 4) | j));
            expect_wr(i, DW'((i << 4) | j));
         end
      for (int t = 1; t <= 16; t++) begin
         neg_after(1);
         chk("t2_winc", 32'(bus.w_inc), 32'd1);
         if (((t - 1) % 4) == 0) chk("t2_grant", 32'(bus.grant), 32'(1 << ((t - 1) / 4)));
      end
      wait_done("t2", 100);
      check_run("t2", n0, c0, 16, 16);

      // Single requester, 6 words, re-granted to itself with no gap
      c0 = cyc;
      n0 = wr_cnt;
      for (int j = 0; j < 6; j++) begin
         load(1, DW'(8'hA0 + j));
         expect_wr(1, DW'(8'hA0 + j));
      end
      neg_after(1);
      chk("t1_grant", 32'(bus.grant), 32'h2);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      neg_after(4);
      chk("t1_regrant", 32'(bus.grant), 32'h2);
      chk("t1_winc5", 32'(bus.w_inc), 32'd1);
      wait_done("t1", 100);
      check_run("t1", n0, c0, 6, 6);
      chk("t1_busy_end", 32'(bus.busy), 32'd0);

      // full for 3 cycles after the 2nd word of req[0]'s burst
      c0 = cyc;
      n0 = wr_cnt;
      for (int j = 0; j < 4; j++) begin
         load(0, DW'(8'hC0 + j));
         expect_wr(0, DW'(8'hC0 + j));
      end
      neg_after(2);
      chk("t3_w2", 32'(bus.wr_data), 32'hC1);
      @(posedge clk);
      #1;
      full_force = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_stall_winc", 32'(bus.w_inc), 32'd0);
         chk("t3_stall_ack", 32'(bus.ack), 32'd0);
         chk("t3_stall_data", 32'(bus.wr_data), 32'hC2);
         chk("t3_stall_grant", 32'(bus.grant), 32'h1);
      end
      @(posedge clk);
      #1;
      full_force = 1'b0;
      wait_done("t3", 100);
      check_run("t3", n0, c0, 4, 7);

      // Owner req[2] withdraws after 2 words, req[3] waiting
      c0 = cyc;
      n0 = wr_cnt;
      load(2, 8'hD0);
      load(2, 8'hD1);
      expect_wr(2, 8'hD0);
      expect_wr(2, 8'hD1);
      for (int j = 0; j < 4; j++) begin
         load(3, DW'(8'hE0 + j));
         expect_wr(3, DW'(8'hE0 + j));
      end
      neg_after(3);
      chk("t4_gap_grant", 32'(bus.grant), 32'h4);
      chk("t4_gap_winc", 32'(bus.w_inc), 32'd0);
      neg_after(1);
      chk("t4_hand_grant", 32'(bus.grant), 32'h8);
      chk("t4_hand_winc", 32'(bus.w_inc), 32'd1);
      chk("t4_hand_data", 32'(bus.wr_data), 32'hE0);
      wait_done("t4", 100);
      check_run("t4", n0, c0, 6, 7);

      // Reset during req[1]'s 3rd word, then req[0] beats req[3]
      c0 = cyc;
      n0 = wr_cnt;
      for (int j = 0; j < 6; j++) load(1, DW'(8'hB0 + j));
      expect_wr(1, 8'hB0);
      expect_wr(1, 8'hB1);
      repeat (3) @(posedge clk);
      #3;
      chk("t5_pre_winc", 32'(bus.w_inc), 32'd1);
      rst = 1'b1;
      flush_gen++;
      #1;
      chk("t5_rst_grant", 32'(bus.grant), 32'd0);
      chk("t5_rst_winc", 32'(bus.w_inc), 32'd0);
      chk("t5_rst_ack", 32'(bus.ack), 32'd0);
      chk("t5_rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      chk("t5_partial", 32'(wr_cnt - n0), 32'd2);
      chk("t5_sb_empty", 32'(sb.size()), 32'd0);
      tick();
      c0 = cyc;
      n0 = wr_cnt;
      for (int j = 0; j < 4; j++) begin
         load(0, DW'(8'h50 + j));
         load(3, DW'(8'h60 + j));
      end
      for (int j = 0; j < 4; j++) expect_wr(0, DW'(8'h50 + j));
      for (int j = 0; j < 4; j++) expect_wr(3, DW'(8'h60 + j));
      neg_after(1);
      chk("t5_first_grant", 32'(bus.grant), 32'h1);
      wait_done("t5", 100);
      check_run("t5", n0, c0, 8, 8);

      // FIFO attached: fill to full, stall, then drain everything exactly once
      fifo_en = 1'b1;
      c0 = cyc;
      n0 = wr_cnt;
      for (int i = 0; i < N; i++)
         for (int w = 0; w < 20; w++) load(i, DW'((i << 5) | w));
      for (int b = 0; b < 5; b++)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < 4; j++) begin
               expect_wr(i, DW'((i << 5) | (b * 4 + j)));
               rd_exp.push_back(DW'((i << 5) | (b * 4 + j)));
            end
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.full) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t6_reached_full", 32'(ok), 32'd1);
      chk("t6_fill_count", 32'(wr_cnt - n0), 32'(DEPTH));
      snap = wr_cnt;
      repeat (10) @(negedge clk);
      chk("t6_stall_no_wr", 32'(wr_cnt), 32'(snap));
      @(posedge clk);
      #1;
      rd_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rd_total >= 80 && fq.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t6_drained", 32'(ok), 32'd1);
      repeat (4) @(negedge clk);
      chk("t6_reads", 32'(rd_total), 32'd80);
      chk("t6_writes", 32'(wr_cnt - n0), 32'd80);
      chk("t6_rd_left", 32'(rd_exp.size()), 32'd0);
      chk("t6_sb_left", 32'(sb.size()), 32'd0);
      chk("t6_idle", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
